rr_decode_arbiter: RTL
======================

# rr_decode_arbiter

Eight-way round-robin arbiter that shares one resource among eight requesters. It holds the current owner as a 3-bit index and drives a one-hot grant, the same 3-to-8 decode pattern the combinational decoder implements, so each requester sees a single dedicated grant line. It sits between the requester bank and the shared resource. It adds fairness rotation, grant hold until release, optional forced preemption after a hold limit, and a global enable.

## Interface
Parameters:
- MAX_HOLD, default 16: maximum consecutive grant cycles before forced preemption when another request is pending. 0 disables preemption. Legal range 0..255.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  arbitration enable. Low blocks new grants; an existing grant is kept until it is released.
- req  in  8  request per requester; bit i belongs to requester i. A requester holds its bit high for as long as it uses the resource.
- gnt  out  8  one-hot grant, registered; all zero when no owner.
- gnt_idx  out  3  registered index of the current owner; holds its last value when gnt_valid=0.
- gnt_valid  out  1  high while any gnt bit is high.
- preempt  out  1  one-cycle pulse on the cycle a grant is forcibly removed.

## Operation
- State: IDLE or BUSY, plus a 3-bit rotate pointer ptr and an 8-bit hold counter hold_cnt.
- Reset values: state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, ptr=0, hold_cnt=0.
- Winner select is combinational: the first i with req[i]=1, scanning ptr, ptr+1, …, ptr+7 (mod 8). For preemption, the current owner is excluded from the scan.
- gnt is always the decode of gnt_idx gated by gnt_valid: gnt[k] = gnt_valid & (gnt_idx==k).
- IDLE: if en=1 and req≠0, the next edge loads gnt_idx=winner, sets gnt_valid=1, sets ptr=winner+1 (wraps 7→0), clears hold_cnt and goes to BUSY. Otherwise the block stays in IDLE.
- BUSY release: if req[gnt_idx]=0 and en=1 with another request pending, the next edge grants the new winner directly, with no idle cycle. If none is pending or en=0, the next edge returns to IDLE with gnt_valid=0.
- BUSY hold: if req[gnt_idx]=1, hold_cnt increments each cycle and saturates at 255.
- BUSY preempt: applies when MAX_HOLD≠0, hold_cnt==MAX_HOLD-1, req[gnt_idx]=1, en=1 and another request is pending. The next edge grants the winner (owner excluded), updates ptr, clears hold_cnt and sets preempt=1 for exactly that one cycle.
- en=0 in BUSY: the owner keeps its grant and preemption is suppressed. The grant is dropped normally on release.
- A request from the owner reasserted on the release cycle is not honoured, because the pointer already sits past it.
- Async reset mid-grant clears every output in the same instant, without waiting for a clock edge.

## Timing
- Grant latency from IDLE: a request sampled high at edge n gives gnt visible after edge n, i.e. a 1-cycle registered latency.
- Handover: the owner's req is sampled low at edge n. The new gnt appears and the old gnt drops at edge n simultaneously. Two gnt bits are never high together.
- Release with no other request: gnt_valid is low after edge n.
- Preempt: the owner holds the grant for exactly MAX_HOLD cycles, then loses it with preempt pulsing for one cycle.
- A grant lasts a minimum of 1 cycle.

## Test plan
- Reset and single request: hold rst_n low, check all outputs 0. Release reset, set req=8'h20 → after one edge gnt=8'h20, gnt_idx=5, gnt_valid=1. Drop req → gnt=0 and gnt_valid=0 after the next edge.
- Round-robin fairness: hold req=8'hFF with each owner releasing after 1 cycle → grant order 0,1,2,…,7,0 with no idle cycles between grants.
- Pointer wrap: owner 6 releases while req=8'h41 → next owner is 0, not 6, and ptr becomes 1.
- Preemption with MAX_HOLD=4: requester 2 holds req and requester 3 requests → gnt=8'h04 for 4 cycles, then gnt=8'h08 with preempt=1 for 1 cycle. With MAX_HOLD=0 the same stimulus keeps gnt=8'h04 indefinitely.
- Enable gating: with owner 1 busy, drop en and request 4 → owner 1 keeps its grant with no preempt. When owner 1 releases → gnt=0. Raise en → one edge later gnt=8'h10.
- Async reset mid-grant: with gnt=8'h80, pulse rst_n low between clock edges → gnt=0 immediately and ptr=0. The first grant after reset with req=8'hFF goes to requester 0.

Source files
------------

// File: rtl/rr_decode_arbiter.sv
// ---------------------------------------------------------------------------
// rr_decode_arbiter
//   Eight-way round-robin arbiter for one shared resource. The current owner
//   is held as a 3-bit index and decoded into a one-hot grant, so every
//   requester sees its own dedicated grant line.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     en         in   arbitration enable; low blocks new grants and
//                     suppresses preemption, an existing grant is kept
//     req[7:0]   in   request per requester, held high while in use
//     gnt[7:0]   out  registered one-hot grant, zero when there is no owner
//     gnt_idx    out  registered owner index, holds when gnt_valid is low
//     gnt_valid  out  high while an owner exists
//     preempt    out  one-cycle pulse on the cycle a grant is forced away
//     dbg_busy   out  FSM state (0 = IDLE, 1 = BUSY)
//     dbg_ptr    out  rotate pointer (first index scanned for a winner)
//
//   Handshake: requester i raises req[i] and keeps it high for as long as it
//   uses the resource; it may use the resource only while gnt[i] is high.
//   Dropping req[i] while owning is the release; the grant falls (or moves
//   to the next winner) on the following edge. A preempted requester sees
//   gnt[i] fall while req[i] is still high and must stop using the resource.
// ---------------------------------------------------------------------------
module rr_decode_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt,
  output logic       dbg_busy,
  output logic [2:0] dbg_ptr
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam bit          PREEMPT_ON  = (MAX_HOLD != 0);
  localparam int unsigned HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [7:0]  HOLD_LAST   = HOLD_LAST_I[7:0];

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       preempt_q, preempt_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  logic [7:0] owner_oh;
  logic [7:0] scan_req;
  logic       win_found;
  logic [2:0] win_idx;

  // While busy the owner is masked out of the scan. On a release its req bit
  // is already low, so the mask only matters for preemption.
  assign owner_oh = 8'h01 << gnt_idx_q;
  assign scan_req = (state_q == BUSY) ? (req & ~owner_oh) : req;

  // First requester at or after ptr, wrapping modulo 8.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int i = 0; i < 8; i++) begin
      if (!win_found && scan_req[ptr_q + 3'(i)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + 3'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;

    case (state_q)
      IDLE: begin
        if (en && win_found) begin
          state_d     = BUSY;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          ptr_d       = win_idx + 3'd1;
          hold_cnt_d  = 8'd0;
        end
      end
      BUSY: begin
        if (!req[gnt_idx_q]) begin
          // Release: hand over directly when possible, otherwise go idle.
          if (en && win_found) begin
            gnt_idx_d   = win_idx;
            ptr_d       = win_idx + 3'd1;
            hold_cnt_d  = 8'd0;
          end else begin
            state_d     = IDLE;
            gnt_valid_d = 1'b0;
          end
        end else if (PREEMPT_ON && (hold_cnt_q == HOLD_LAST) && en && win_found) begin
          // hold_cnt reads MAX_HOLD-1 during the owner's MAX_HOLD-th cycle.
          gnt_idx_d  = win_idx;
          ptr_d      = win_idx + 3'd1;
          hold_cnt_d = 8'd0;
          preempt_d  = 1'b1;
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase

    gnt_d = gnt_valid_d ? (8'h01 << gnt_idx_d) : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 8'h00;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      ptr_q       <= 3'd0;
      hold_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;
  assign dbg_busy  = (state_q == BUSY);
  assign dbg_ptr   = ptr_q;

endmodule
